// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - ownership arbiter for the shared MCU / SD-passthrough SPI pins
//
// Decides whether the control MCU or the middleboard SD passthrough owns SCK
// and SPI_DO. Every handover passes through a GUARD window with both grants
// low. SD ownership is capped while the MCU is waiting, and contention is
// reported through a sticky flag and a saturating counter.
//
// Ports:
//   CLOCK_50       system clock
//   RESET_N        asynchronous active-low reset
//   mcu_ss_n[3:0]  active-low MCU selects {SS4, SS3, SS2, CONF_DATA0}, asynchronous
//   sd_sck         middleboard SD clock, asynchronous, activity detection only
//   clr_collision  synchronous pulse clearing collision and collision_cnt
//   sck_sel        1 = route MCU SCK, 0 = route SD_SCK
//   sd_do_en       1 = drive SPI_DO from SD_MISO, 0 = hi-Z
//   mcu_grant      MCU owns the bus
//   sd_grant       SD passthrough owns the bus
//   collision      sticky contention flag
//   collision_cnt  saturating contention count
//   state          0 IDLE, 1 MCU_OWN, 2 SD_OWN, 3 GUARD

module spi_bus_arbiter #(
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = 4,
    parameter int IDLE_TIMEOUT = 64,
    parameter int SD_MAX_HOLD  = 4096,
    parameter int CNT_W        = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [3:0]       mcu_ss_n,
    input  logic             sd_sck,
    input  logic             clr_collision,
    output logic             sck_sel,
    output logic             sd_do_en,
    output logic             mcu_grant,
    output logic             sd_grant,
    output logic             collision,
    output logic [CNT_W-1:0] collision_cnt,
    output logic [1:0]       state
);

    localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);
    localparam int HOLD_W  = $clog2(SD_MAX_HOLD + 1);
    localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MCU   = 2'd1,
        ST_SD    = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][3:0] mcu_sync_q;
    logic [SYNC_STAGES-1:0]      sck_sync_q;
    logic                        sck_prev_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mcu_sync_q <= {SYNC_STAGES{4'hF}};
            sck_sync_q <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            mcu_sync_q <= {mcu_sync_q[SYNC_STAGES-2:0], mcu_ss_n};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sd_sck};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    logic mcu_req;
    logic sd_edge;
    logic sd_req;

    assign mcu_req = ~&mcu_sync_q[SYNC_STAGES-1];
    assign sd_edge = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;

    // ------------------------------------------------------------------
    // Arbiter state
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic               mcu_grant_q, mcu_grant_d;
    logic               sd_grant_q, sd_grant_d;
    logic               sck_sel_q, sck_sel_d;
    logic               sd_do_en_q, sd_do_en_d;
    logic               collision_q, collision_d;
    logic [CNT_W-1:0]   coll_cnt_q, coll_cnt_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic               mcu_seen_q, mcu_seen_d;
    logic               sd_wait_q, sd_wait_d;
    logic               coll_evt;

    // idle_q counts down from IDLE_TIMEOUT after each SD clock edge; the SD
    // side is considered active while it is non-zero.
    assign sd_req = (idle_q != '0);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        guard_d    = guard_q;
        mcu_seen_d = mcu_seen_q;
        coll_evt   = 1'b0;

        if (sd_edge) begin
            idle_d = IDLE_W'(IDLE_TIMEOUT);
        end else if (idle_q != '0) begin
            idle_d = idle_q - IDLE_W'(1);
        end else begin
            idle_d = idle_q;
        end

        // SD counts as a waiting party only while it keeps clocking.
        sd_wait_d = sd_wait_q & (sd_req | sd_edge);

        case (state_q)
            ST_IDLE: begin
                // MCU wins ties unless SD was the one kept waiting.
                if (mcu_req && !(sd_wait_q && sd_req)) begin
                    state_d = ST_MCU;
                end else if (sd_edge || sd_req) begin
                    state_d    = ST_SD;
                    hold_d     = '0;
                    mcu_seen_d = 1'b0;
                    sd_wait_d  = 1'b0;
                end
            end

            ST_MCU: begin
                if (sd_edge) begin
                    coll_evt  = 1'b1;
                    sd_wait_d = 1'b1;
                end
                if (!mcu_req) begin
                    state_d = ST_GUARD;
                    guard_d = '0;
                end
            end

            ST_SD: begin
                if (hold_q != HOLD_W'(SD_MAX_HOLD)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                // Each new MCU request arriving during SD ownership is one collision.
                if (mcu_req && !mcu_seen_q) begin
                    coll_evt   = 1'b1;
                    mcu_seen_d = 1'b1;
                end else if (!mcu_req) begin
                    mcu_seen_d = 1'b0;
                end
                if (!sd_edge && idle_q <= IDLE_W'(1)) begin
                    state_d = ST_GUARD;
                    guard_d = '0;
                end else if (mcu_req && hold_q >= HOLD_W'(SD_MAX_HOLD - 1)) begin
                    state_d  = ST_GUARD;
                    guard_d  = '0;
                    coll_evt = 1'b1;
                end
            end

            default: begin
                if (guard_q == GUARD_W'(GUARD_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q + GUARD_W'(1);
                end
            end
        endcase

        // Outputs follow the next state so they register alongside it.
        mcu_grant_d = 1'b0;
        sd_grant_d  = 1'b0;
        sck_sel_d   = 1'b1;
        sd_do_en_d  = 1'b0;
        case (state_d)
            ST_MCU: begin
                mcu_grant_d = 1'b1;
            end
            ST_SD: begin
                sd_grant_d = 1'b1;
                sck_sel_d  = 1'b0;
                sd_do_en_d = 1'b1;
            end
            default: begin
                mcu_grant_d = 1'b0;
            end
        endcase

        // A clear in the same cycle as a new collision drops the collision.
        if (clr_collision) begin
            collision_d = 1'b0;
            coll_cnt_d  = '0;
        end else if (coll_evt) begin
            collision_d = 1'b1;
            coll_cnt_d  = (&coll_cnt_q) ? coll_cnt_q : coll_cnt_q + CNT_W'(1);
        end else begin
            collision_d = collision_q;
            coll_cnt_d  = coll_cnt_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            mcu_grant_q <= 1'b0;
            sd_grant_q  <= 1'b0;
            sck_sel_q   <= 1'b1;
            sd_do_en_q  <= 1'b0;
            collision_q <= 1'b0;
            coll_cnt_q  <= '0;
            idle_q      <= '0;
            hold_q      <= '0;
            guard_q     <= '0;
            mcu_seen_q  <= 1'b0;
            sd_wait_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcu_grant_q <= mcu_grant_d;
            sd_grant_q  <= sd_grant_d;
            sck_sel_q   <= sck_sel_d;
            sd_do_en_q  <= sd_do_en_d;
            collision_q <= collision_d;
            coll_cnt_q  <= coll_cnt_d;
            idle_q      <= idle_d;
            hold_q      <= hold_d;
            guard_q     <= guard_d;
            mcu_seen_q  <= mcu_seen_d;
            sd_wait_q   <= sd_wait_d;
        end
    end

    assign sck_sel       = sck_sel_q;
    assign sd_do_en      = sd_do_en_q;
    assign mcu_grant     = mcu_grant_q;
    assign sd_grant      = sd_grant_q;
    assign collision     = collision_q;
    assign collision_cnt = coll_cnt_q;
    assign state         = state_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - scoreboard bench for spi_bus_arbiter
module tb_spi_bus_arbiter;

    localparam int CNT_W = 8;

    logic             CLOCK_50 = 1'b0;
    logic             RESET_N = 1'b0;
    logic [3:0]       mcu_ss_n = 4'hF;
    logic             sd_sck = 1'b0;
    logic             clr_collision = 1'b0;
    logic             sck_sel;
    logic             sd_do_en;
    logic             mcu_grant;
    logic             sd_grant;
    logic             collision;
    logic [CNT_W-1:0] collision_cnt;
    logic [1:0]       state;

    spi_bus_arbiter #(
        .SYNC_STAGES(2), .GUARD_CYCLES(4), .IDLE_TIMEOUT(64),
        .SD_MAX_HOLD(4096), .CNT_W(CNT_W)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .mcu_ss_n(mcu_ss_n),
        .sd_sck(sd_sck), .clr_collision(clr_collision), .sck_sel(sck_sel),
        .sd_do_en(sd_do_en), .mcu_grant(mcu_grant), .sd_grant(sd_grant),
        .collision(collision), .collision_cnt(collision_cnt), .state(state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct { int st; int cy; } st_exp_t;
    typedef struct { int flag; int cnt; int cy; } col_exp_t;
    st_exp_t  st_q[$];
    col_exp_t col_q[$];

    bit mon_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_st(input int s, input int cy);
        st_exp_t e;
        e.st = s;
        e.cy = cy;
        st_q.push_back(e);
    endtask

    task automatic push_col(input int f, input int n, input int cy);
        col_exp_t e;
        e.flag = f;
        e.cnt = n;
        e.cy = cy;
        col_q.push_back(e);
    endtask

    // Monitor: every change of state or collision outputs pops one expectation.
    always @(negedge CLOCK_50) begin : monitor
        st_exp_t  se;
        col_exp_t ce;
        int       last_st;
        int       last_flag;
        int       last_cnt;
        if (!mon_on) begin
            last_st = 0;
            last_flag = 0;
            last_cnt = 0;
        end else begin
            if (int'(state) != last_st) begin
                last_st = int'(state);
                if (st_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_state: got %0d, expected no change (cycle %0d)", state, cyc);
                end else begin
                    se = st_q.pop_front();
                    check("state", int'(state), se.st);
                    if (se.cy >= 0) check("state_cycle", cyc, se.cy);
                    check("mcu_grant", int'(mcu_grant), int'(se.st == 1));
                    check("sd_grant", int'(sd_grant), int'(se.st == 2));
                    check("sck_sel", int'(sck_sel), int'(se.st != 2));
                    check("sd_do_en", int'(sd_do_en), int'(se.st == 2));
                end
            end
            if (int'(collision) != last_flag || int'(collision_cnt) != last_cnt) begin
                last_flag = int'(collision);
                last_cnt = int'(collision_cnt);
                if (col_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_collision: got %0d/%0d, expected no change (cycle %0d)",
                             collision, collision_cnt, cyc);
                end else begin
                    ce = col_q.pop_front();
                    check("collision", int'(collision), ce.flag);
                    check("collision_cnt", int'(collision_cnt), ce.cnt);
                    if (ce.cy >= 0) check("collision_cycle", cyc, ce.cy);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        int c0;
        int s_own;
        int last_rise;

        // Reset and quiescent behaviour
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        mon_on = 1'b1;
        check("rst_sck_sel", int'(sck_sel), 1);
        check("rst_sd_do_en", int'(sd_do_en), 0);
        check("rst_mcu_grant", int'(mcu_grant), 0);
        check("rst_sd_grant", int'(sd_grant), 0);
        check("rst_collision", int'(collision), 0);
        check("rst_collision_cnt", int'(collision_cnt), 0);
        check("rst_state", int'(state), 0);
        repeat (20) @(negedge CLOCK_50);
        check("quiet_state", int'(state), 0);
        check("quiet_sck_sel", int'(sck_sel), 1);
        check("quiet_sd_do_en", int'(sd_do_en), 0);

        // MCU select 2: grant after 3 cycles, then 4 GUARD cycles
        c = cyc;
        mcu_ss_n[2] = 1'b0;
        push_st(1, c + 3);
        repeat (10) @(negedge CLOCK_50);
        c = cyc;
        mcu_ss_n = 4'hF;
        push_st(3, c + 3);
        push_st(0, c + 7);
        repeat (15) @(negedge CLOCK_50);

        // SD activity: edges every 20 cycles, timeout 64 cycles after last
        c0 = cyc;
        last_rise = c0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) repeat (10) @(negedge CLOCK_50);
            sd_sck = ~sd_sck;
            if (sd_sck) last_rise = cyc;
            if (i == 0) push_st(2, c0 + 3);
        end
        push_st(3, last_rise + 67);
        push_st(0, last_rise + 71);
        repeat (80) @(negedge CLOCK_50);

        // MCU waits on busy SD: one collision on request, one on forced handover
        c0 = cyc;
        s_own = c0 + 3;
        push_st(2, s_own);
        for (int k = 0; k < 204; k++) begin
            sd_sck = 1'b1;
            if (k == 2) begin
                mcu_ss_n[0] = 1'b0;
                push_col(1, 1, cyc + 3);
                push_st(3, s_own + 4096);
                push_col(1, 2, s_own + 4096);
                push_st(0, s_own + 4100);
                push_st(1, s_own + 4101);
            end
            repeat (10) @(negedge CLOCK_50);
            sd_sck = 1'b0;
            repeat (10) @(negedge CLOCK_50);
        end
        repeat (100) @(negedge CLOCK_50);
        check("forced_mcu_grant", int'(mcu_grant), 1);
        c = cyc;
        clr_collision = 1'b1;
        push_col(0, 0, c + 1);
        @(negedge CLOCK_50);
        clr_collision = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        c = cyc;
        mcu_ss_n = 4'hF;
        push_st(3, c + 3);
        push_st(0, c + 7);
        repeat (15) @(negedge CLOCK_50);

        // Simultaneous MCU select and SD edge in IDLE: MCU wins
        c = cyc;
        mcu_ss_n[1] = 1'b0;
        sd_sck = 1'b1;
        push_st(1, c + 3);
        repeat (10) @(negedge CLOCK_50);
        check("tie_mcu_grant", int'(mcu_grant), 1);
        check("tie_sd_grant", int'(sd_grant), 0);
        sd_sck = 1'b0;
        repeat (10) @(negedge CLOCK_50);

        // 300 SD edges during MCU ownership saturate the counter at 255
        for (int k = 1; k <= 300; k++) begin
            sd_sck = 1'b1;
            if (k <= 255) push_col(1, k, cyc + 3);
            repeat (2) @(negedge CLOCK_50);
            sd_sck = 1'b0;
            repeat (2) @(negedge CLOCK_50);
        end
        repeat (10) @(negedge CLOCK_50);
        check("sat_collision_cnt", int'(collision_cnt), 255);
        c = cyc;
        clr_collision = 1'b1;
        push_col(0, 0, c + 1);
        @(negedge CLOCK_50);
        clr_collision = 1'b0;
        repeat (80) @(negedge CLOCK_50);
        c = cyc;
        mcu_ss_n = 4'hF;
        push_st(3, c + 3);
        push_st(0, c + 7);
        repeat (15) @(negedge CLOCK_50);

        // Asynchronous reset while SD owns the bus
        c = cyc;
        sd_sck = 1'b1;
        push_st(2, c + 3);
        repeat (10) @(negedge CLOCK_50);
        check("pre_reset_sd_do_en", int'(sd_do_en), 1);
        @(posedge CLOCK_50);
        #2;
        push_st(0, -1);
        RESET_N = 1'b0;
        #1;
        check("async_sd_do_en", int'(sd_do_en), 0);
        check("async_sd_grant", int'(sd_grant), 0);
        check("async_sck_sel", int'(sck_sel), 1);
        check("async_state", int'(state), 0);
        sd_sck = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (20) @(negedge CLOCK_50);

        check("state_queue_drained", st_q.size(), 0);
        check("collision_queue_drained", col_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
